// File: rtl/v_pkg.sv
// Shared types for the vector sequencer: unit encodings, FSM states, micro-op
// descriptor and the decoded-instruction unit-select priority.
package v_pkg;

  typedef enum logic [2:0] {
    VUNIT_NONE = 3'd0,
    VUNIT_ALU  = 3'd1,
    VUNIT_MUL  = 3'd2,
    VUNIT_RED  = 3'd3,
    VUNIT_SLDU = 3'd4,
    VUNIT_LSU  = 3'd5
  } v_unit_t;

  typedef enum logic [0:0] {
    VSEQ_IDLE  = 1'b0,
    VSEQ_ISSUE = 1'b1
  } vseq_state_t;

  typedef struct packed {
    v_unit_t    unit;
    logic [3:0] op;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
  } v_uop_t;

  // Unit priority below vconfig: LSU > RED > SLDU > MUL > ALU.
  function automatic v_unit_t sel_unit(input logic [3:0] lsu_op,
                                       input logic [2:0] red_op,
                                       input logic [2:0] sldu_op,
                                       input logic       mul,
                                       input logic [3:0] alu_op);
    v_unit_t u;
    if (lsu_op != 4'd0) begin
      u = VUNIT_LSU;
    end else if (red_op != 3'd0) begin
      u = VUNIT_RED;
    end else if (sldu_op != 3'd0) begin
      u = VUNIT_SLDU;
    end else if (mul) begin
      u = VUNIT_MUL;
    end else if (alu_op != 4'd0) begin
      u = VUNIT_ALU;
    end else begin
      u = VUNIT_NONE;
    end
    return u;
  endfunction

endpackage

// File: rtl/v_sequencer.sv
// Vector sequencer: accepts one decoded instruction, owns vl, and splits each
// instruction into LANES-wide element-group micro-ops over a valid/ready port.
module v_sequencer
  import v_pkg::*;
#(
  parameter int LANES = 4,
  parameter int VLMAX = 32,
  parameter int VLW   = $clog2(VLMAX + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_vconfig,
  input  logic [3:0]       v_alu_op,
  input  logic             is_mul,
  input  logic [2:0]       v_red_op,
  input  logic [2:0]       v_sldu_op,
  input  logic [3:0]       v_lsu_op,
  input  logic [4:0]       vd,
  input  logic [4:0]       vs1,
  input  logic [4:0]       vs2,
  input  logic [VLW:0]     avl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_unit,
  output logic [3:0]       out_op,
  output logic [4:0]       out_vd,
  output logic [4:0]       out_vs1,
  output logic [4:0]       out_vs2,
  output logic [VLW-1:0]   out_eidx,
  output logic [LANES-1:0] out_emask,
  output logic             out_last,
  output logic [VLW-1:0]   vl,
  output logic             busy,
  output logic             illegal
);

  localparam logic [VLW:0] VLMAX_X = (VLW + 1)'(VLMAX);
  localparam logic [VLW:0] LANES_X = (VLW + 1)'(LANES);

  vseq_state_t      state_q, state_d;
  logic [VLW-1:0]   vl_q, vl_d;
  logic [VLW-1:0]   eidx_q, eidx_d;
  v_uop_t           uop_q, uop_d;
  logic             illegal_q, illegal_d;

  v_unit_t          unit_s;
  logic [3:0]       op_s;
  logic [VLW:0]     eidx_next_s;
  logic [LANES-1:0] emask_s;
  logic             last_s;
  logic             issue_s;

  assign issue_s = (state_q == VSEQ_ISSUE);

  // Decode target unit and unit-local opcode of the presented instruction.
  always_comb begin
    unit_s = sel_unit(v_lsu_op, v_red_op, v_sldu_op, is_mul, v_alu_op);
    case (unit_s)
      VUNIT_LSU:  op_s = v_lsu_op;
      VUNIT_RED:  op_s = {1'b0, v_red_op};
      VUNIT_SLDU: op_s = {1'b0, v_sldu_op};
      VUNIT_MUL:  op_s = v_alu_op;
      VUNIT_ALU:  op_s = v_alu_op;
      default:    op_s = 4'd0;
    endcase
  end

  // Per-lane active mask and last-group flag; one extra bit keeps eidx+LANES from wrapping.
  always_comb begin
    eidx_next_s = {1'b0, eidx_q} + LANES_X;
    last_s      = (eidx_next_s >= {1'b0, vl_q});
    emask_s     = '0;
    for (int i = 0; i < LANES; i++) begin
      emask_s[i] = (({1'b0, eidx_q} + (VLW + 1)'(i)) < {1'b0, vl_q});
    end
  end

  // Next-state logic for the IDLE/ISSUE sequencer.
  always_comb begin
    state_d   = state_q;
    vl_d      = vl_q;
    eidx_d    = eidx_q;
    uop_d     = uop_q;
    illegal_d = 1'b0;
    case (state_q)
      VSEQ_IDLE: begin
        if (in_valid) begin
          if (is_vconfig) begin
            if (avl > VLMAX_X) begin
              vl_d = VLMAX_X[VLW-1:0];
            end else begin
              vl_d = avl[VLW-1:0];
            end
          end else if (unit_s == VUNIT_NONE) begin
            illegal_d = 1'b1;
          end else if (vl_q == '0) begin
            state_d = VSEQ_IDLE;
          end else begin
            uop_d.unit = unit_s;
            uop_d.op   = op_s;
            uop_d.vd   = vd;
            uop_d.vs1  = vs1;
            uop_d.vs2  = vs2;
            eidx_d     = '0;
            state_d    = VSEQ_ISSUE;
          end
        end else begin
          state_d = VSEQ_IDLE;
        end
      end
      VSEQ_ISSUE: begin
        if (out_ready) begin
          if (last_s) begin
            state_d = VSEQ_IDLE;
          end else begin
            eidx_d = eidx_next_s[VLW-1:0];
          end
        end else begin
          state_d = VSEQ_ISSUE;
        end
      end
      default: begin
        state_d = VSEQ_IDLE;
      end
    endcase
  end

  // State, vl and latched micro-op registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= VSEQ_IDLE;
      vl_q      <= VLMAX_X[VLW-1:0];
      eidx_q    <= '0;
      uop_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vl_q      <= vl_d;
      eidx_q    <= eidx_d;
      uop_q     <= uop_d;
      illegal_q <= illegal_d;
    end
  end

  // Micro-op fields read as zero whenever no micro-op is being offered.
  always_comb begin
    out_valid = issue_s;
    out_unit  = issue_s ? uop_q.unit : VUNIT_NONE;
    out_op    = issue_s ? uop_q.op   : 4'd0;
    out_vd    = issue_s ? uop_q.vd   : 5'd0;
    out_vs1   = issue_s ? uop_q.vs1  : 5'd0;
    out_vs2   = issue_s ? uop_q.vs2  : 5'd0;
    out_eidx  = issue_s ? eidx_q     : '0;
    out_emask = issue_s ? emask_s    : '0;
    out_last  = issue_s & last_s;
  end

  assign in_ready = (state_q == VSEQ_IDLE);
  assign busy     = issue_s;
  assign vl       = vl_q;
  assign illegal  = illegal_q;

endmodule
